// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and branch squash.
// Define ID_EX_STALL_COUNT_EN to add the StallCount bubble counter output.
module id_ex_stage_reg #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [4:0]  ZERO_REG   = 5'd31
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  input  logic                  Flush,
  input  logic [4:0]            IF_ID_RegisterRn1,
  input  logic [4:0]            IF_ID_RegisterRm2,
  input  logic [4:0]            IF_ID_RegisterRd,
  input  logic [DATA_WIDTH-1:0] ID_ReadData1,
  input  logic [DATA_WIDTH-1:0] ID_ReadData2,
  input  logic [DATA_WIDTH-1:0] ID_SignExtImm,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  ID_MemWrite,
  input  logic                  ID_MemtoReg,
  input  logic                  ID_ALUSrc,
  input  logic                  ID_Branch,
  input  logic [1:0]            ID_ALUOp,
  output logic [4:0]            ID_EX_RegisterRn1,
  output logic [4:0]            ID_EX_RegisterRm2,
  output logic [4:0]            ID_EX_RegisterRd,
  output logic [DATA_WIDTH-1:0] ID_EX_ReadData1,
  output logic [DATA_WIDTH-1:0] ID_EX_ReadData2,
  output logic [DATA_WIDTH-1:0] ID_EX_SignExtImm,
  output logic                  ID_EX_RegWrite,
  output logic                  ID_EX_MemRead,
  output logic                  ID_EX_MemWrite,
  output logic                  ID_EX_MemtoReg,
  output logic                  ID_EX_ALUSrc,
  output logic                  ID_EX_Branch,
  output logic [1:0]            ID_EX_ALUOp,
`ifdef ID_EX_STALL_COUNT_EN
  output logic [31:0]           StallCount,
`endif
  output logic                  PCWrite,
  output logic                  IF_ID_Write
);

  logic hazard;
  logic stall;
  logic load_bubble;

  assign hazard = ID_EX_MemRead && (ID_EX_RegisterRd != ZERO_REG) &&
                  ((ID_EX_RegisterRd == IF_ID_RegisterRn1) ||
                   (ID_EX_RegisterRd == IF_ID_RegisterRm2));

  // A flush discards IF/ID anyway, so it wins over the stall.
  assign stall       = hazard && !Flush;
  assign load_bubble = Flush || hazard;
  assign PCWrite     = !stall;
  assign IF_ID_Write = !stall;

  // Bubble specifiers point at XZR so forwarding and hazard compares never match.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      ID_EX_RegisterRn1 <= ZERO_REG;
      ID_EX_RegisterRm2 <= ZERO_REG;
      ID_EX_RegisterRd  <= ZERO_REG;
      ID_EX_ReadData1   <= '0;
      ID_EX_ReadData2   <= '0;
      ID_EX_SignExtImm  <= '0;
      ID_EX_RegWrite    <= 1'b0;
      ID_EX_MemRead     <= 1'b0;
      ID_EX_MemWrite    <= 1'b0;
      ID_EX_MemtoReg    <= 1'b0;
      ID_EX_ALUSrc      <= 1'b0;
      ID_EX_Branch      <= 1'b0;
      ID_EX_ALUOp       <= 2'b00;
    end else if (load_bubble) begin
      ID_EX_RegisterRn1 <= ZERO_REG;
      ID_EX_RegisterRm2 <= ZERO_REG;
      ID_EX_RegisterRd  <= ZERO_REG;
      ID_EX_ReadData1   <= '0;
      ID_EX_ReadData2   <= '0;
      ID_EX_SignExtImm  <= '0;
      ID_EX_RegWrite    <= 1'b0;
      ID_EX_MemRead     <= 1'b0;
      ID_EX_MemWrite    <= 1'b0;
      ID_EX_MemtoReg    <= 1'b0;
      ID_EX_ALUSrc      <= 1'b0;
      ID_EX_Branch      <= 1'b0;
      ID_EX_ALUOp       <= 2'b00;
    end else begin
      ID_EX_RegisterRn1 <= IF_ID_RegisterRn1;
      ID_EX_RegisterRm2 <= IF_ID_RegisterRm2;
      ID_EX_RegisterRd  <= IF_ID_RegisterRd;
      ID_EX_ReadData1   <= ID_ReadData1;
      ID_EX_ReadData2   <= ID_ReadData2;
      ID_EX_SignExtImm  <= ID_SignExtImm;
      ID_EX_RegWrite    <= ID_RegWrite;
      ID_EX_MemRead     <= ID_MemRead;
      ID_EX_MemWrite    <= ID_MemWrite;
      ID_EX_MemtoReg    <= ID_MemtoReg;
      ID_EX_ALUSrc      <= ID_ALUSrc;
      ID_EX_Branch      <= ID_Branch;
      ID_EX_ALUOp       <= ID_ALUOp;
    end
  end

`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0] stall_cnt;

  // Counts only hazard bubbles; wraps naturally at 32 bits.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt <= '0;
    end else if (stall) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: random and directed ID traffic vs. an instruction-level model.
// Honours ID_EX_STALL_COUNT_EN to also check StallCount.
module tb_id_ex_stage_reg;

  localparam int unsigned DW = 64;

  logic          CLOCK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          Flush = 1'b0;
  logic [4:0]    IF_ID_RegisterRn1 = '0, IF_ID_RegisterRm2 = '0, IF_ID_RegisterRd = '0;
  logic [DW-1:0] ID_ReadData1 = '0, ID_ReadData2 = '0, ID_SignExtImm = '0;
  logic          ID_RegWrite = 1'b0, ID_MemRead = 1'b0, ID_MemWrite = 1'b0;
  logic          ID_MemtoReg = 1'b0, ID_ALUSrc = 1'b0, ID_Branch = 1'b0;
  logic [1:0]    ID_ALUOp = '0;
  logic [4:0]    ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_RegisterRd;
  logic [DW-1:0] ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm;
  logic          ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite;
  logic          ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch;
  logic [1:0]    ID_EX_ALUOp;
  logic          PCWrite, IF_ID_Write;
`ifdef ID_EX_STALL_COUNT_EN
  logic [31:0]   StallCount;
`endif

  id_ex_stage_reg #(.DATA_WIDTH(DW), .ZERO_REG(5'd31)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .Flush(Flush),
    .IF_ID_RegisterRn1(IF_ID_RegisterRn1), .IF_ID_RegisterRm2(IF_ID_RegisterRm2),
    .IF_ID_RegisterRd(IF_ID_RegisterRd),
    .ID_ReadData1(ID_ReadData1), .ID_ReadData2(ID_ReadData2), .ID_SignExtImm(ID_SignExtImm),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_Branch(ID_Branch),
    .ID_ALUOp(ID_ALUOp),
    .ID_EX_RegisterRn1(ID_EX_RegisterRn1), .ID_EX_RegisterRm2(ID_EX_RegisterRm2),
    .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
    .ID_EX_SignExtImm(ID_EX_SignExtImm),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch), .ID_EX_ALUOp(ID_EX_ALUOp),
`ifdef ID_EX_STALL_COUNT_EN
    .StallCount(StallCount),
`endif
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {
    logic [4:0]    rn, rm, rd;
    logic [DW-1:0] d1, d2, imm;
    logic          rw, mr, mw, m2r, as, br;
    logic [1:0]    op;
  } instr_t;

  typedef struct {
    instr_t      st;
    logic        pcw;
    logic [31:0] cnt;
  } exp_t;

  exp_t   q[$];
  instr_t cur;        // model: instruction currently held in EX
  logic [31:0] cnt;   // model: hazard bubbles so far
  int     total = 0;
  int     passed = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic instr_t bubble();
    instr_t b = '0;
    b.rn = 5'd31; b.rm = 5'd31; b.rd = 5'd31;
    return b;
  endfunction

  function automatic instr_t dut_state();
    instr_t s;
    s.rn = ID_EX_RegisterRn1; s.rm = ID_EX_RegisterRm2; s.rd = ID_EX_RegisterRd;
    s.d1 = ID_EX_ReadData1; s.d2 = ID_EX_ReadData2; s.imm = ID_EX_SignExtImm;
    s.rw = ID_EX_RegWrite; s.mr = ID_EX_MemRead; s.mw = ID_EX_MemWrite;
    s.m2r = ID_EX_MemtoReg; s.as = ID_EX_ALUSrc; s.br = ID_EX_Branch; s.op = ID_EX_ALUOp;
    return s;
  endfunction

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
  endfunction

  function automatic instr_t rand_instr();
    instr_t r;
    r.rn = pick_reg(); r.rm = pick_reg(); r.rd = pick_reg();
    r.d1 = {$urandom, $urandom}; r.d2 = {$urandom, $urandom}; r.imm = {$urandom, $urandom};
    r.rw = 1'($urandom); r.mr = ($urandom_range(0, 2) == 0); r.mw = 1'($urandom);
    r.m2r = 1'($urandom); r.as = 1'($urandom); r.br = 1'($urandom); r.op = 2'($urandom);
    return r;
  endfunction

  // A later instruction stalls when it reads the register an EX-stage load writes (XZR excluded).
  function automatic logic load_use(input instr_t ex, input instr_t id);
    return ex.mr && ex.rd != 5'd31 && (id.rn == ex.rd || id.rm == ex.rd);
  endfunction

  task automatic drive_and_push(input instr_t in, input logic fl);
    exp_t e;
    logic hz;
    IF_ID_RegisterRn1 = in.rn; IF_ID_RegisterRm2 = in.rm; IF_ID_RegisterRd = in.rd;
    ID_ReadData1 = in.d1; ID_ReadData2 = in.d2; ID_SignExtImm = in.imm;
    ID_RegWrite = in.rw; ID_MemRead = in.mr; ID_MemWrite = in.mw; ID_MemtoReg = in.m2r;
    ID_ALUSrc = in.as; ID_Branch = in.br; ID_ALUOp = in.op; Flush = fl;
    hz = load_use(cur, in);
    if (hz && !fl) cnt = cnt + 32'd1;
    cur = (fl || hz) ? bubble() : in;
    e.st = cur; e.pcw = !(hz && !fl); e.cnt = cnt;
    q.push_back(e);
  endtask

  task automatic step(input instr_t in, input logic fl);
    @(negedge CLOCK);
    drive_and_push(in, fl);
  endtask

  // Monitor: stall outputs sampled mid-cycle, register contents just after the edge.
  logic pcw_s, ifw_s;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      #2;
      pcw_s = PCWrite;
      ifw_s = IF_ID_Write;
      @(posedge CLOCK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pcwrite", 256'(pcw_s), 256'(e.pcw));
        chk("if_id_write", 256'(ifw_s), 256'(e.pcw));
        chk("id_ex_state", 256'(dut_state()), 256'(e.st));
`ifdef ID_EX_STALL_COUNT_EN
        chk("stall_count", 256'(StallCount), 256'(e.cnt));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

  initial begin
    instr_t nop, ld, add;
    nop = '0; nop.rn = 5'd31; nop.rm = 5'd31; nop.rd = 5'd31;
    cur = bubble();
    cnt = '0;

    // Reset held for two cycles
    RESET_N = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("reset_state", 256'(dut_state()), 256'(bubble()));
    chk("reset_pcwrite", 256'(PCWrite), 256'(1));
`ifdef ID_EX_STALL_COUNT_EN
    chk("reset_stall_count", 256'(StallCount), 256'(0));
`endif
    @(negedge CLOCK);
    RESET_N = 1'b1;
    drive_and_push(nop, 1'b0);

    // Pass-through
    add = '0; add.rn = 5'd2; add.rm = 5'd3; add.rd = 5'd4; add.rw = 1'b1; add.d1 = 64'h10;
    step(add, 1'b0);

    // Load-use on Rn1: one bubble then the held ADD is captured
    step(nop, 1'b0);
    ld = rand_instr(); ld.mr = 1'b1; ld.rd = 5'd5; ld.rn = 5'd1; ld.rm = 5'd2;
    step(ld, 1'b0);
    add = rand_instr(); add.mr = 1'b0; add.rn = 5'd5; add.rm = 5'd6;
    step(add, 1'b0);
    step(add, 1'b0);

    // Hazard on Rm2 alone, then on both
    step(ld, 1'b0);
    add.rn = 5'd6; add.rm = 5'd5;
    step(add, 1'b0);
    step(add, 1'b0);
    step(ld, 1'b0);
    add.rn = 5'd5;
    step(add, 1'b0);
    step(add, 1'b0);

    // Load into XZR never stalls
    ld.rd = 5'd31;
    step(ld, 1'b0);
    add.rn = 5'd1; add.rm = 5'd31;
    step(add, 1'b0);

    // Flush together with a hazard: bubble, no stall, no count
    ld.rd = 5'd5;
    step(nop, 1'b0);
    step(ld, 1'b0);
    add.rn = 5'd5;
    step(add, 1'b1);

`ifdef ID_EX_STALL_COUNT_EN
    // Counter wrap from all-ones
    step(nop, 1'b0);
    step(ld, 1'b0);
    @(negedge CLOCK);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    cnt = 32'hFFFF_FFFF;
    drive_and_push(add, 1'b0);
    step(add, 1'b0);
`endif

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(rand_instr(), ($urandom_range(0, 9) == 0));
    end

    // Reset asserted mid-stall releases the stall immediately
    step(nop, 1'b0);
    step(ld, 1'b0);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    add.rn = 5'd5; add.rm = 5'd7;
    IF_ID_RegisterRn1 = add.rn; IF_ID_RegisterRm2 = add.rm; Flush = 1'b0;
    #2;
    chk("pre_reset_stall", 256'(PCWrite), 256'(!load_use(cur, add)));
    #1;
    RESET_N = 1'b0;
    #1;
    cur = bubble();
    cnt = '0;
    chk("async_reset_state", 256'(dut_state()), 256'(bubble()));
    chk("async_reset_pcwrite", 256'(PCWrite), 256'(1));
`ifdef ID_EX_STALL_COUNT_EN
    chk("async_reset_count", 256'(StallCount), 256'(0));
`endif
    @(negedge CLOCK);
    RESET_N = 1'b1;
    drive_and_push(add, 1'b0);
    for (int i = 0; i < 50; i++) begin
      step(rand_instr(), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(posedge CLOCK);
    #2;
    chk("scoreboard_drained", 256'(q.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
